// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM states, parity modes and baud default
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    // 100 MHz core clock at 115200 baud
    localparam int UART_CLK_DIV_DEFAULT = 868;

    // Zero-extension of narrower words leaves the reduction XOR unchanged
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - show-ahead FIFO read port between TX FIFO and controller
interface uart_tx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_pop;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - loadable down-counter with zero flag for UART bit timing
module uart_baud_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - drains the TX FIFO and serializes each byte onto the UART line
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = PARITY_MODE_EVEN,
    parameter int STOP_BITS  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_en,
    uart_tx_ctrl_if.master         fifo,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic PAR_INV  = (PARITY_ODD == PARITY_MODE_ODD);
    localparam logic ONE_STOP = (STOP_BITS == 1);

    uart_state_e       state_q, state_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              last_stop_q, last_stop_d;
    logic              tx_q, tx_d;
    logic              baud_load;
    logic              baud_zero;
    logic              start_ok;
    logic              pop;
    logic              done;

    uart_baud_cnt #(
        .CNT_W(BAUD_W)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (baud_load),
        .load_val_i(BAUD_RELOAD),
        .zero_o    (baud_zero)
    );

    // rst_n gates the pop so a FIFO entry is never lost while in reset
    assign start_ok = rst_n && tx_en && !fifo.fifo_empty;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        last_stop_d = last_stop_q;
        baud_load   = 1'b0;
        pop         = 1'b0;
        done        = 1'b0;
        tx_d        = 1'b1;

        case (state_q)
            IDLE: begin
                pop = start_ok;
            end
            START: begin
                if (baud_zero) begin
                    state_d   = DATA;
                    bit_cnt_d = BCNT_W'(DATA_W);
                    baud_load = 1'b1;
                end
            end
            DATA: begin
                if (baud_zero) begin
                    baud_load = 1'b1;
                    if (bit_cnt_q == BCNT_W'(1)) begin
                        bit_cnt_d   = '0;
                        last_stop_d = ONE_STOP;
                        state_d     = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BCNT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_zero) begin
                    state_d     = STOP;
                    last_stop_d = ONE_STOP;
                    baud_load   = 1'b1;
                end
            end
            STOP: begin
                if (baud_zero) begin
                    if (last_stop_q) begin
                        done    = 1'b1;
                        pop     = start_ok;
                        state_d = IDLE;
                    end else begin
                        last_stop_d = 1'b1;
                        baud_load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture is shared by the idle start and the back-to-back start
        if (pop) begin
            state_d   = START;
            baud_load = 1'b1;
            shift_d   = fifo.fifo_rd_data;
            parity_d  = calc_parity(64'(fifo.fifo_rd_data), PAR_INV);
        end

        // tx is registered, so it follows the state being entered
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            last_stop_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            last_stop_q <= last_stop_d;
            tx_q        <= tx_d;
        end
    end

    assign fifo.fifo_pop = pop;
    assign tx            = tx_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = done;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized bench for uart_tx_ctrl against a line-waveform model
module tb_uart_tx_ctrl;
    localparam int CLK_DIV = 4;
    localparam int NINST   = 3;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_en;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instance 0: 8N1, instance 1: 8E2, instance 2: 8O1
    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int PE = (g == 0) ? 0 : 1;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 1) ? 2 : 1;

        uart_tx_ctrl_if #(.DATA_W(8)) fif ();
        logic       tx_w, busy_w, done_w;
        logic [7:0] fq[$];
        slot_t      exp_q[$];
        int         pop_cnt  = 0;
        int         cyc      = 0;
        int         rise_cyc = 0;
        int         fall_cyc = 0;
        logic       prev_busy = 1'b0;
        logic       pend_pop  = 1'b0;

        uart_tx_ctrl #(
            .DATA_W    (8),
            .CLK_DIV   (CLK_DIV),
            .PARITY_EN (PE),
            .PARITY_ODD(PO),
            .STOP_BITS (SB)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_en     (tx_en),
            .fifo      (fif),
            .tx        (tx_w),
            .busy      (busy_w),
            .frame_done(done_w)
        );

        // Show-ahead FIFO: pops land after the edge, head refreshed afterwards
        initial begin
            fif.fifo_empty   = 1'b1;
            fif.fifo_rd_data = 8'h00;
            forever begin
                @(posedge clk);
                #1;
                if (pend_pop && fq.size() != 0) fq.delete(0);
                #1;
                fif.fifo_empty   = (fq.size() == 0);
                fif.fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
            end
        end

        always @(negedge clk) begin
            slot_t      cur;
            logic       exp_pop;
            logic [7:0] b;
            logic       bits[$];
            cyc++;
            cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            check($sformatf("i%0d_tx_c%0d", g, cyc), 32'(tx_w), 32'(cur.tx));
            check($sformatf("i%0d_busy_c%0d", g, cyc), 32'(busy_w), 32'(cur.busy));
            check($sformatf("i%0d_done_c%0d", g, cyc), 32'(done_w), 32'(cur.done));
            exp_pop = rst_n && tx_en && (exp_q.size() == 0) && (fq.size() != 0);
            check($sformatf("i%0d_pop_c%0d", g, cyc), 32'(fif.fifo_pop), 32'(exp_pop));
            pend_pop = fif.fifo_pop;
            if (fif.fifo_pop) pop_cnt++;
            if (busy_w && !prev_busy) rise_cyc = cyc;
            if (!busy_w && prev_busy) fall_cyc = cyc;
            prev_busy = busy_w;
            if (!rst_n) begin
                exp_q.delete();
            end else if (exp_pop) begin
                b = fq[0];
                bits.delete();
                bits.push_back(1'b0);
                for (int i = 0; i < 8; i++) bits.push_back(b[i]);
                if (PE != 0) bits.push_back((^b) ^ (PO != 0));
                for (int i = 0; i < SB; i++) bits.push_back(1'b1);
                for (int k = 0; k < bits.size(); k++)
                    for (int c = 0; c < CLK_DIV; c++)
                        exp_q.push_back('{tx: bits[k], busy: 1'b1,
                                          done: (k == bits.size() - 1) && (c == CLK_DIV - 1)});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_all(input logic [7:0] b);
        g_inst[0].fq.push_back(b);
        g_inst[1].fq.push_back(b);
        g_inst[2].fq.push_back(b);
        n_pushed++;
    endtask

    function automatic bit model_idle();
        bit q_idle;
        bit f_idle;
        q_idle = (g_inst[0].exp_q.size() == 0) && (g_inst[1].exp_q.size() == 0) &&
                 (g_inst[2].exp_q.size() == 0);
        f_idle = (g_inst[0].fq.size() == 0) && (g_inst[1].fq.size() == 0) &&
                 (g_inst[2].fq.size() == 0);
        return q_idle && (!tx_en || f_idle);
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!model_idle() && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= 3000), 0);
        tick(3);
    endtask

    // Frame lengths: 8N1 = 10 bits, 8E2 = 12 bits, 8O1 = 11 bits, 4 clocks each
    task automatic check_all(input string tag, input int pops, input int fill, input int nframes);
        check({tag, "_i0_pops"}, g_inst[0].pop_cnt, pops);
        check({tag, "_i1_pops"}, g_inst[1].pop_cnt, pops);
        check({tag, "_i2_pops"}, g_inst[2].pop_cnt, pops);
        check({tag, "_i0_fill"}, g_inst[0].fq.size(), fill);
        check({tag, "_i1_fill"}, g_inst[1].fq.size(), fill);
        check({tag, "_i2_fill"}, g_inst[2].fq.size(), fill);
        check({tag, "_i0_txidle"}, 32'(g_inst[0].tx_w), 1);
        check({tag, "_i1_txidle"}, 32'(g_inst[1].tx_w), 1);
        check({tag, "_i2_txidle"}, 32'(g_inst[2].tx_w), 1);
        check({tag, "_i0_busy"}, 32'(g_inst[0].busy_w), 0);
        check({tag, "_i1_busy"}, 32'(g_inst[1].busy_w), 0);
        check({tag, "_i2_busy"}, 32'(g_inst[2].busy_w), 0);
        if (nframes != 0) begin
            check({tag, "_i0_span"}, g_inst[0].fall_cyc - g_inst[0].rise_cyc, nframes * 40);
            check({tag, "_i1_span"}, g_inst[1].fall_cyc - g_inst[1].rise_cyc, nframes * 48);
            check({tag, "_i2_span"}, g_inst[2].fall_cyc - g_inst[2].rise_cyc, nframes * 44);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tx_en = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_all("reset", 0, 0, 0);

        tx_en = 1'b1;
        tick(100);
        check_all("empty", 0, 0, 0);

        push_all(8'hA5);
        wait_idle("a5");
        check_all("a5", 1, 0, 1);

        tx_en = 1'b0;
        push_all(8'h01);
        push_all(8'h80);
        push_all(8'hFF);
        tick(5);
        tx_en = 1'b1;
        wait_idle("b2b");
        check_all("b2b", 4, 0, 3);

        tx_en = 1'b0;
        push_all(8'h07);
        push_all(8'($urandom));
        tick(1);
        tx_en = 1'b1;
        tick(10);
        tx_en = 1'b0;
        wait_idle("txen_off");
        check_all("txen_off", 5, 1, 1);
        tx_en = 1'b1;
        wait_idle("txen_on");
        check_all("txen_on", 6, 0, 1);

        tx_en = 1'b0;
        push_all(8'($urandom));
        push_all(8'($urandom));
        tick(1);
        tx_en = 1'b1;
        tick(12);
        rst_n = 1'b0;
        tick(1);
        check_all("rst_edge", 7, 1, 0);
        rst_n = 1'b1;
        wait_idle("rst");
        check_all("rst", 8, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0 && g_inst[0].fq.size() < 8) push_all(8'($urandom));
            if ($urandom_range(0, 149) == 0) tx_en = ~tx_en;
            tick(1);
        end
        tx_en = 1'b1;
        wait_idle("rand");
        check_all("rand", n_pushed, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller that drains the byte FIFO and serializes each entry onto the UART tx line.
- Sits between the TX FIFO (show-ahead: read data valid combinationally whenever not empty) and the pad.
- Owns the FIFO pop, baud timing, framing (start/data/optional parity/stop) and line idling.
- Frames go out back-to-back while data is available and transmission is enabled.

Parameters:
DATA_W, 8, data bits per frame; must match the FIFO width.
CLK_DIV, 868, clk cycles per bit (100 MHz / 115200); legal range is >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
tx_en  in  1  allow new frames to start; does not abort a frame already in flight
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  DATA_W  FIFO head entry (show-ahead)
fifo_pop  out  1  one-cycle pop strobe to the FIFO
tx  out  1  serial line; registered output; idles high
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset state: tx = 1, fifo_pop = 0, busy = 0, frame_done = 0. FSM goes to IDLE, baud and bit counters clear, shift register clears.
- Reset asserted mid-frame: tx = 1 at the next edge and the frame is abandoned. No pop is issued during reset.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE, with tx_en = 1 and fifo_empty = 0 in cycle T:
  - fifo_pop = 1 in cycle T (combinational from state and inputs).
  - fifo_rd_data is captured into the shift register at the edge ending T.
  - The FSM moves to START.
- tx timing: tx drives 0 from cycle T+1, so latency from pop to start-bit edge is 1 cycle.
- Bit timing:
  - The baud counter loads CLK_DIV-1 on entry to every bit and decrements.
  - The bit ends in the cycle the counter reads 0, so every bit lasts exactly CLK_DIV cycles.
  - Counter width is $clog2(CLK_DIV).
- Data bits:
  - DATA holds DATA_W bits, LSB first; the shift register shifts right once per bit.
  - The bit counter has width $clog2(DATA_W+1).
- Parity:
  - Computed as the XOR of the captured byte, taken at capture time.
  - The bit is inverted when PARITY_ODD = 1.
  - The PARITY state is skipped when PARITY_EN = 0.
- STOP: tx = 1 for STOP_BITS*CLK_DIV cycles. frame_done pulses in the last cycle.
- Total frame length is exactly (1 + DATA_W + PARITY_EN + STOP_BITS) * CLK_DIV cycles.
- Back-to-back frames: in the last STOP cycle, if tx_en = 1 and fifo_empty = 0:
  - pop in that same cycle and go directly to START (no idle gap).
  - otherwise go to IDLE.
- tx_en deasserted mid-frame: the current frame completes normally and no further pop occurs.
- Empty FIFO: fifo_pop is never asserted while fifo_empty = 1.
- Pop rate: at most one pop per frame.
- Pushes into the FIFO during a frame do not affect the frame in flight.
- busy = (state != IDLE). It stays high across back-to-back frames.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE/START/DATA/PARITY/STOP);
  - the parity-mode constants;
  - the default CLK_DIV constant.
  The future uart_rx_ctrl reuses all three.
- One sub-module, uart_baud_cnt: a loadable down-counter with a zero flag, shared with RX.

Test Plan:
- CLK_DIV=4, no parity, 1 stop; push 0xA5 with tx_en=1:
  - one fifo_pop;
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - frame 40 cycles; frame_done in cycle 40; busy then drops.
- Push 0x01, 0x80, 0xFF before enabling, then raise tx_en:
  - three frames back-to-back with no idle cycle between stop and start;
  - exactly 3 pops;
  - FIFO empty afterwards; tx=1 and busy=0 at the end.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1. PARITY_ODD=1, byte 0x07 -> parity bit 0. STOP_BITS=2 -> stop holds 8 cycles; frame 48 cycles.
- Deassert tx_en during the DATA state with 2 entries queued -> current frame completes, no second pop, and the FIFO still holds 1 entry.
- Assert rst_n=0 for 1 cycle in the middle of the data bits -> tx=1 and busy=0 at the next edge. After release, the next queued byte transmits cleanly.
- tx_en=1 with an empty FIFO for 100 cycles -> fifo_pop never asserted and tx stays 1.
